// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue gate and D-stage stall generator in front of MUL_DIV.
// Tracks unit occupancy from the issue cycle (ARM, before busy rises) through
// BUSY. It also provides a busy watchdog, sticky protocol/timeout flags and a
// counter of issued start ops.
//
// Handshake: an op is presented to MUL_DIV on md_op for exactly the cycle it is
// accepted. There is no ready. MUL_DIV must raise md_busy in the next cycle for
// start ops and hold it until done. Move ops never raise md_busy.
module md_issue_ctrl #(
  parameter int unsigned MAX_BUSY = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d_md_op,
  input  logic        d_md_read,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic        flush,
  input  logic        md_busy,
  output logic [3:0]  md_op,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic        stall_md,
  output logic        err_proto,
  output logic        err_timeout,
  output logic [15:0] issue_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_BUSY = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BUSY_C = 8'(MAX_BUSY);

  state_t      state_q, state_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [7:0]  wdog_inc;
  logic [15:0] cnt_q, cnt_d;
  logic        err_proto_q, err_proto_d;
  logic        err_timeout_q, err_timeout_d;

  logic [3:0]  e_op_eff;
  logic [3:0]  d_op_eff;
  logic        idle;
  logic        e_is_start;
  logic        e_start;
  logic        d_md;

  // Encodings 7..15 behave as "no op" everywhere.
  assign e_op_eff   = (e_md_op <= 4'd6) ? e_md_op : 4'd0;
  assign d_op_eff   = (d_md_op <= 4'd6) ? d_md_op : 4'd0;
  assign idle       = (state_q == S_IDLE);
  assign e_is_start = (e_op_eff != 4'd0) && (e_op_eff <= 4'd4);
  // rst_n gates issue so nothing reaches MUL_DIV while reset is held.
  assign e_start    = rst_n && idle && e_is_start && !flush;
  assign d_md       = (d_op_eff != 4'd0) || d_md_read;
  assign wdog_inc   = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;

  // Issue path depends only on state, flush and the E op, never on md_busy.
  assign md_op    = (rst_n && idle && !flush) ? e_op_eff : 4'd0;
  assign md_d1    = e_rs_val;
  assign md_d2    = e_rt_val;
  assign stall_md = d_md && (!idle || e_start || md_busy);

  assign err_proto   = err_proto_q;
  assign err_timeout = err_timeout_q;
  assign issue_cnt   = cnt_q;
  assign state_o     = state_q;

  // Next-state, watchdog, counter and sticky flag logic.
  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    cnt_d         = cnt_q;
    err_proto_d   = err_proto_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (e_start) begin
          state_d = S_ARM;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_ARM: begin
        if (md_busy) begin
          state_d = S_BUSY;
          wdog_d  = 8'd0;
        end else begin
          state_d     = S_IDLE;
          err_proto_d = 1'b1;
        end
      end
      S_BUSY: begin
        if (!md_busy) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc >= MAX_BUSY_C) begin
            err_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Another md op arriving while the unit is occupied is a decode/hazard bug;
    // a flushed one is harmless because it never would have executed.
    if (!idle && (e_op_eff != 4'd0) && !flush) begin
      err_proto_d = 1'b1;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wdog_q        <= 8'd0;
      cnt_q         <= 16'd0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      cnt_q         <= cnt_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: directed scenarios plus a randomized run with a
// simple MUL_DIV busy generator, checked against an occupancy-level model.
module tb_md_issue_ctrl;

  localparam int MAXB = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  d_md_op;
  logic        d_md_read;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs_val;
  logic [31:0] e_rt_val;
  logic        flush;
  logic        md_busy;
  logic [3:0]  md_op;
  logic [31:0] md_d1;
  logic [31:0] md_d2;
  logic        stall_md;
  logic        err_proto;
  logic        err_timeout;
  logic [15:0] issue_cnt;
  logic [1:0]  state_o;

  md_issue_ctrl #(.MAX_BUSY(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .d_md_op(d_md_op), .d_md_read(d_md_read),
    .e_md_op(e_md_op), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
    .flush(flush), .md_busy(md_busy), .md_op(md_op), .md_d1(md_d1),
    .md_d2(md_d2), .stall_md(stall_md), .err_proto(err_proto),
    .err_timeout(err_timeout), .issue_cnt(issue_cnt), .state_o(state_o)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: is the unit occupied, was it issued last cycle, how many
  // cycles has busy been held, plus counter and sticky flags.
  bit m_occ;
  bit m_armed;
  int m_wd;
  int m_cnt;
  bit m_proto;
  bit m_to;
  bit m_issued;

  logic       got_stall;
  logic [1:0] got_state;
  logic [3:0] got_op;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_armed = 0; m_wd = 0; m_cnt = 0; m_proto = 0; m_to = 0; m_issued = 0;
  endtask

  // One clock cycle: drive at edge+1, check at edge+3, update the model at the edge.
  task automatic step(input logic [3:0] eop, input logic [3:0] dop, input logic dread,
                      input logic fl, input logic busy, input logic [31:0] rs,
                      input logic [31:0] rt);
    int  eff;
    bit  start_ok;
    bit  dmd;
    int  exp_op;
    int  exp_state;
    e_md_op = eop; d_md_op = dop; d_md_read = dread; flush = fl; md_busy = busy;
    e_rs_val = rs; e_rt_val = rt;
    #2;
    eff       = (eop <= 6) ? int'(eop) : 0;
    start_ok  = !m_occ && (eff >= 1) && (eff <= 4) && !fl;
    dmd       = (dop >= 1 && dop <= 6) || dread;
    exp_op    = (!m_occ && !fl) ? eff : 0;
    exp_state = !m_occ ? 0 : (m_armed ? 1 : 2);
    check_eq("md_op", 32'(md_op), 32'(exp_op));
    check_eq("md_d1", md_d1, rs);
    check_eq("md_d2", md_d2, rt);
    check_eq("stall_md", 32'(stall_md), 32'(dmd && (m_occ || start_ok || busy)));
    check_eq("state", 32'(state_o), 32'(exp_state));
    check_eq("issue_cnt", 32'(issue_cnt), 32'(m_cnt & 16'hFFFF));
    check_eq("err_proto", 32'(err_proto), 32'(m_proto));
    check_eq("err_timeout", 32'(err_timeout), 32'(m_to));
    got_stall = stall_md; got_state = state_o; got_op = md_op;
    @(posedge clk);
    m_issued = start_ok;
    if (m_occ && eff != 0 && !fl) m_proto = 1;
    if (!m_occ) begin
      if (start_ok) begin m_cnt++; m_occ = 1; m_armed = 1; end
    end else if (m_armed) begin
      m_armed = 0;
      if (!busy) begin m_proto = 1; m_occ = 0; end
      else m_wd = 0;
    end else begin
      if (!busy) m_occ = 0;
      else begin
        if (m_wd < 255) m_wd++;
        if (m_wd >= MAXB) m_to = 1;
      end
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges; checks take effect immediately.
  task automatic do_reset();
    bit dmd;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    dmd = (d_md_op >= 1 && d_md_op <= 6) || d_md_read;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_cnt", 32'(issue_cnt), 32'd0);
    check_eq("rst_proto", 32'(err_proto), 32'd0);
    check_eq("rst_timeout", 32'(err_timeout), 32'd0);
    check_eq("rst_md_op", 32'(md_op), 32'd0);
    check_eq("rst_stall", 32'(stall_md), 32'(dmd && md_busy));
    e_md_op = 4'd0; flush = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int         exp_st[8] = '{0, 1, 2, 2, 2, 2, 2, 0};
  logic       rec_stall[8];
  logic [1:0] rec_state[8];
  logic [3:0] rec_op[8];
  int         busy_rem;
  logic [31:0] rs_neg6, rt_neg3;

  initial begin
    rst_n = 1'b1; d_md_op = 0; d_md_read = 0; e_md_op = 4'd1; flush = 0; md_busy = 0;
    e_rs_val = 0; e_rt_val = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Reset then mult with a 5-cycle busy pulse and an mflo waiting in D.
    rs_neg6 = -32'sd6; rt_neg3 = -32'sd3;
    for (int i = 0; i < 8; i++) begin
      step((i == 0) ? 4'd1 : 4'd0, 4'd0, 1'b1, 1'b0, (i >= 1 && i <= 5), rs_neg6, rt_neg3);
      rec_stall[i] = got_stall; rec_state[i] = got_state; rec_op[i] = got_op;
    end
    for (int i = 0; i < 8; i++) begin
      check_eq("mult_stall_seq", 32'(rec_stall[i]), 32'(i <= 6));
      check_eq("mult_state_seq", 32'(rec_state[i]), 32'(exp_st[i]));
      check_eq("mult_op_seq", 32'(rec_op[i]), (i == 0) ? 32'd1 : 32'd0);
    end
    check_eq("mult_cnt", 32'(issue_cnt), 32'd1);

    // mthi followed by mflo in D: zero occupancy, no stall.
    do_reset();
    step(4'd5, 4'd0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h5678);
    check_eq("mthi_op", 32'(got_op), 32'd5);
    check_eq("mthi_stall", 32'(got_stall), 32'd0);
    check_eq("mthi_state", 32'(state_o), 32'd0);
    check_eq("mthi_cnt", 32'(issue_cnt), 32'd0);

    // Flushed div: nothing issued, nothing counted.
    step(4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    check_eq("flush_op", 32'(got_op), 32'd0);
    check_eq("flush_state", 32'(state_o), 32'd0);
    check_eq("flush_cnt", 32'(issue_cnt), 32'd0);

    // Start issued but busy never rises.
    do_reset();
    step(4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    check_eq("noBusy_proto", 32'(err_proto), 32'd1);
    check_eq("noBusy_state", 32'(state_o), 32'd0);

    // multu arriving while BUSY is suppressed and flagged.
    do_reset();
    step(4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 32'd9, 32'd3);
    step(4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 32'd9, 32'd3);
    check_eq("busyOp_md_op", 32'(got_op), 32'd0);
    check_eq("busyOp_proto", 32'(err_proto), 32'd1);
    step(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3);

    // Watchdog: busy held high past MAX_BUSY cycles in BUSY.
    do_reset();
    step(4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
    step(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
    for (int i = 0; i < MAXB; i++) begin
      if (i == MAXB - 2) check_eq("to_early", 32'(err_timeout), 32'd0);
      step(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
    end
    check_eq("to_flag", 32'(err_timeout), 32'd1);
    check_eq("to_state", 32'(state_o), 32'd2);
    check_eq("to_stall", 32'(stall_md), 32'd1);

    // Async reset mid-BUSY with busy dropped, then with busy still high.
    md_busy = 1'b0; d_md_read = 1'b1;
    do_reset();
    step(4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4);
    step(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd4);
    step(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd4);
    md_busy = 1'b1;
    do_reset();
    step(4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 32'd4, 32'd4);
    check_eq("rstBusy_stall", 32'(got_stall), 32'd1);
    step(4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 32'd4, 32'd4);

    // Randomized run with a MUL_DIV stand-in generating busy after each start.
    busy_rem = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [3:0] eop;
      logic [3:0] dop;
      if (c % 70 == 69) begin
        md_busy = (busy_rem > 0); d_md_op = 4'($urandom_range(0, 15));
        d_md_read = 1'($urandom_range(0, 1));
        do_reset();
        continue;
      end
      if (m_occ) eop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      else       eop = 4'($urandom_range(0, 15));
      dop = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step(eop, dop, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
           (busy_rem > 0), $urandom, $urandom);
      if (m_issued) busy_rem = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      else if (busy_rem > 0) busy_rem--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
